// File: rtl/tt_sweep_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker_pkg
// Description : Shared types and constants for the truth-table sweep checker:
//               sweep state encoding, exercise truth tables and a helper that
//               sizes the settle counter.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_checker_pkg;

    // Sweep controller states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    // Golden truth tables for the two-input exercise family (bit i = f(i)).
    localparam logic [3:0] c_TT_XOR = 4'b0110;
    localparam logic [3:0] c_TT_AND = 4'b1000;
    localparam logic [3:0] c_TT_OR  = 4'b1110;

    // Width of a counter that must reach settle-1; never narrower than 1 bit.
    function automatic int tt_wait_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage : tt_sweep_checker_pkg
`default_nettype wire

// File: rtl/tt_vec_counter.sv
`default_nettype none
// ============================================================================
// Module      : tt_vec_counter
// Description : Input-vector register (clear / increment / last flag) plus
//               the settle wait counter used between vector changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_vec_counter
    import tt_sweep_checker_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vec_clr,
    input  logic         i_vec_inc,
    input  logic         i_wait_clr,
    input  logic         i_wait_inc,
    output logic [N-1:0] o_vec,
    output logic         o_vec_last,
    output logic         o_wait_last
);

    localparam int              c_WW        = tt_wait_width(SETTLE);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(SETTLE - 1);

    logic [N-1:0]    r_vec;
    logic [c_WW-1:0] r_wcnt;

    // Vector register: cleared at sweep start, stepped after each sample.
    always_ff @(posedge clk) begin
        if (rst || i_vec_clr) begin
            r_vec <= '0;
        end else if (i_vec_inc) begin
            r_vec <= r_vec + 1'b1;
        end
    end

    // Settle counter: counts edges the current vector has been held.
    always_ff @(posedge clk) begin
        if (rst || i_wait_clr) begin
            r_wcnt <= '0;
        end else if (i_wait_inc) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    assign o_vec       = r_vec;
    assign o_vec_last  = (r_vec == {N{1'b1}});
    assign o_wait_last = (r_wcnt == c_WAIT_LAST);

endmodule : tt_vec_counter
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker
// Description : Sweeps every N-bit input vector in ascending order, lets the
//               gate pair settle, then compares the two implementation
//               outputs with each other and with a golden truth table.
//               Reports mismatch counts and the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int              N      = 2,
    parameter int              SETTLE = 1,
    parameter logic [2**N-1:0] TRUTH  = c_TT_XOR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] x,
    input  logic         a_in,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   ab_err,
    output logic [N:0]   gold_err,
    output logic [N-1:0] first_fail,
    output logic         fail_seen
);

    tt_state_t    r_state, w_state_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_done, w_done_nxt;
    logic         r_pass, w_pass_nxt;
    logic [N:0]   r_ab_err, w_ab_err_nxt;
    logic [N:0]   r_gold_err, w_gold_err_nxt;
    logic [N-1:0] r_first_fail, w_first_fail_nxt;
    logic         r_fail_seen, w_fail_seen_nxt;

    logic         w_vec_clr, w_vec_inc, w_wait_clr, w_wait_inc;
    logic [N-1:0] w_x;
    logic         w_vec_last, w_wait_last;
    logic         w_ab_mis, w_gold_mis;

    tt_vec_counter #(
        .N      (N),
        .SETTLE (SETTLE)
    ) u_vec_counter (
        .clk         (clk),
        .rst         (rst),
        .i_vec_clr   (w_vec_clr),
        .i_vec_inc   (w_vec_inc),
        .i_wait_clr  (w_wait_clr),
        .i_wait_inc  (w_wait_inc),
        .o_vec       (w_x),
        .o_vec_last  (w_vec_last),
        .o_wait_last (w_wait_last)
    );

    // Case-inequality so an X/Z from either implementation is a mismatch.
    assign w_ab_mis   = (a_in !== b_in);
    assign w_gold_mis = (a_in !== TRUTH[w_x]);

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_ab_err     <= '0;
            r_gold_err   <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_ab_err     <= w_ab_err_nxt;
            r_gold_err   <= w_gold_err_nxt;
            r_first_fail <= w_first_fail_nxt;
            r_fail_seen  <= w_fail_seen_nxt;
        end
    end

    // Next-state, counter control and result updates.
    always_comb begin
        w_state_nxt      = r_state;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_pass_nxt       = r_pass;
        w_ab_err_nxt     = r_ab_err;
        w_gold_err_nxt   = r_gold_err;
        w_first_fail_nxt = r_first_fail;
        w_fail_seen_nxt  = r_fail_seen;
        w_vec_clr        = 1'b0;
        w_vec_inc        = 1'b0;
        w_wait_clr       = 1'b0;
        w_wait_inc       = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                // start is only honoured when no sweep is running.
                if (start) begin
                    w_state_nxt      = WAIT;
                    w_busy_nxt       = 1'b1;
                    w_done_nxt       = 1'b0;
                    w_pass_nxt       = 1'b0;
                    w_ab_err_nxt     = '0;
                    w_gold_err_nxt   = '0;
                    w_first_fail_nxt = '0;
                    w_fail_seen_nxt  = 1'b0;
                    w_vec_clr        = 1'b1;
                    w_wait_clr       = 1'b1;
                end
            end

            WAIT: begin
                if (w_wait_last) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            SAMPLE: begin
                w_ab_err_nxt   = r_ab_err + {{N{1'b0}}, w_ab_mis};
                w_gold_err_nxt = r_gold_err + {{N{1'b0}}, w_gold_mis};
                if ((w_ab_mis || w_gold_mis) && !r_fail_seen) begin
                    w_first_fail_nxt = w_x;
                    w_fail_seen_nxt  = 1'b1;
                end
                if (w_vec_last) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // Pass is judged on the counts including this last vector.
                    w_pass_nxt  = (w_ab_err_nxt == '0) && (w_gold_err_nxt == '0);
                end else begin
                    w_state_nxt = WAIT;
                    w_vec_inc   = 1'b1;
                    w_wait_clr  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign x          = w_x;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign ab_err     = r_ab_err;
    assign gold_err   = r_gold_err;
    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;

endmodule : tt_sweep_checker
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_checker
// Description : Self-checking bench for tt_sweep_checker. Two instances
//               (N=2/SETTLE=1/XOR and N=3/SETTLE=3/XOR3) are driven by
//               table-modelled gate pairs; expectations come from a sweep
//               model computed over the tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;
    import tt_sweep_checker_pkg::*;

    localparam int         c_S0 = 1;
    localparam logic [3:0] c_T0 = c_TT_XOR;
    localparam int         c_S1 = 3;
    localparam logic [7:0] c_T1 = 8'b1001_0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic [3:0] a_tab0, b_tab0;
    logic [7:0] a_tab1, b_tab1;

    logic [1:0] x0, ff0;
    logic [2:0] ab0, gold0;
    logic       a_in0, b_in0, busy0, done0, pass0, fs0;
    logic [2:0] x1, ff1;
    logic [3:0] ab1, gold1;
    logic       a_in1, b_in1, busy1, done1, pass1, fs1;

    // Gate pair under test modelled as lookup tables on the driven vector.
    assign a_in0 = a_tab0[x0];
    assign b_in0 = b_tab0[x0];
    assign a_in1 = a_tab1[x1];
    assign b_in1 = b_tab1[x1];

    tt_sweep_checker #(.N(2), .SETTLE(c_S0), .TRUTH(c_T0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x(x0), .a_in(a_in0), .b_in(b_in0),
        .busy(busy0), .done(done0), .pass(pass0), .ab_err(ab0), .gold_err(gold0),
        .first_fail(ff0), .fail_seen(fs0)
    );

    tt_sweep_checker #(.N(3), .SETTLE(c_S1), .TRUTH(c_T1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .a_in(a_in1), .b_in(b_in1),
        .busy(busy1), .done(done1), .pass(pass1), .ab_err(ab1), .gold_err(gold1),
        .first_fail(ff1), .fail_seen(fs1)
    );

    int checks   = 0;
    int failures = 0;

    // Selected instance, observed through one common view.
    logic        sel;
    logic [31:0] ob_x, ob_ab, ob_gold, ob_ff, ob_busy, ob_done, ob_pass, ob_fs;

    always_comb begin
        if (!sel) begin
            ob_x = 32'(x0);     ob_ab = 32'(ab0);   ob_gold = 32'(gold0); ob_ff = 32'(ff0);
            ob_busy = 32'(busy0); ob_done = 32'(done0); ob_pass = 32'(pass0); ob_fs = 32'(fs0);
        end else begin
            ob_x = 32'(x1);     ob_ab = 32'(ab1);   ob_gold = 32'(gold1); ob_ff = 32'(ff1);
            ob_busy = 32'(busy1); ob_done = 32'(done1); ob_pass = 32'(pass1); ob_fs = 32'(fs1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s sel=%0d got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic chk_reset_state();
        chk("rst_x", ob_x, 0);       chk("rst_busy", ob_busy, 0);
        chk("rst_done", ob_done, 0); chk("rst_pass", ob_pass, 0);
        chk("rst_ab", ob_ab, 0);     chk("rst_gold", ob_gold, 0);
        chk("rst_ff", ob_ff, 0);     chk("rst_fs", ob_fs, 0);
    endtask

    // One full sweep on the selected instance, checked edge by edge against
    // the expected schedule and the expected final results.
    task automatic run_sweep(input bit extra_starts);
        int         nn, st, nv, len, e_ab, e_gold, e_ff;
        bit         e_fs, av, bv, tv;
        logic [7:0] at, bt, tt;
        nn  = sel ? 3 : 2;
        st  = sel ? c_S1 : c_S0;
        nv  = 1 << nn;
        len = nv * (st + 1);
        at  = sel ? a_tab1 : {4'b0, a_tab0};
        bt  = sel ? b_tab1 : {4'b0, b_tab0};
        tt  = sel ? c_T1 : {4'b0, c_T0};
        e_ab = 0; e_gold = 0; e_ff = 0; e_fs = 0;
        for (int v = 0; v < nv; v++) begin
            av = at[v]; bv = bt[v]; tv = tt[v];
            if (av != bv) e_ab++;
            if (av != tv) e_gold++;
            if (((av != bv) || (av != tv)) && !e_fs) begin
                e_fs = 1'b1;
                e_ff = v;
            end
        end

        @(negedge clk);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        chk("start_busy", ob_busy, 1); chk("start_done", ob_done, 0);
        chk("start_x", ob_x, 0);       chk("start_ab", ob_ab, 0);
        chk("start_gold", ob_gold, 0); chk("start_fs", ob_fs, 0);

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            set_start(extra_starts && (k == 3 || k == 5));
            @(posedge clk); #1;
            set_start(1'b0);
            chk("sweep_x", ob_x, (k < len) ? k / (st + 1) : nv - 1);
            chk("sweep_done", ob_done, 32'(k == len));
            chk("sweep_busy", ob_busy, 32'(k < len));
        end

        chk("ab_err", ob_ab, e_ab);
        chk("gold_err", ob_gold, e_gold);
        chk("pass", ob_pass, 32'(e_ab == 0 && e_gold == 0));
        chk("fail_seen", ob_fs, 32'(e_fs));
        chk("first_fail", ob_ff, e_ff);

        repeat (2) @(posedge clk);
        #1;
        chk("hold_done", ob_done, 1);
        chk("hold_x", ob_x, nv - 1);
        chk("hold_ab", ob_ab, e_ab);
        chk("hold_gold", ob_gold, e_gold);
    endtask

    task automatic random_tables(input int mode);
        logic [7:0] r;
        r = 8'($urandom);
        if (!sel) begin
            a_tab0 = (mode == 2) ? r[7:4] : c_T0;
            b_tab0 = (mode == 0) ? c_T0 : r[3:0];
        end else begin
            a_tab1 = (mode == 2) ? 8'($urandom) : c_T1;
            b_tab1 = (mode == 0) ? c_T1 : r;
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
        a_tab0 = c_T0; b_tab0 = c_T0; a_tab1 = c_T1; b_tab1 = c_T1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        sel = 1'b1; #1;
        chk_reset_state();
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Correct XOR pair.
        run_sweep(1'b0);
        // b stuck at 0, a correct XOR: vectors 1 and 2 disagree.
        b_tab0 = 4'b0000;
        run_sweep(1'b0);
        // a is AND, b is XOR: vectors 1,2,3 wrong on both counts.
        a_tab0 = c_TT_AND; b_tab0 = c_TT_XOR;
        run_sweep(1'b0);
        // Correct pair restarted from DONE with ignored mid-sweep starts.
        a_tab0 = c_T0; b_tab0 = c_T0;
        run_sweep(1'b1);
        run_sweep(1'b1);

        // Reset mid-sweep at edge 4 aborts everything.
        a_tab0 = c_TT_OR; b_tab0 = c_TT_AND;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state();
        @(posedge clk); #1;
        chk("idle_x", ob_x, 0);
        chk("idle_busy", ob_busy, 0);
        run_sweep(1'b0);

        for (int i = 0; i < 6; i++) begin
            random_tables(int'($urandom_range(0, 2)));
            run_sweep(i[0]);
        end

        // Three-input instance, SETTLE=3.
        sel = 1'b1;
        run_sweep(1'b0);
        for (int i = 0; i < 4; i++) begin
            random_tables(int'($urandom_range(0, 2)));
            run_sweep(1'b0);
        end

        // Simultaneous rst and start from DONE: reset wins.
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0;
        chk("rst_start_busy", ob_busy, 0);
        chk("rst_start_done", ob_done, 0);
        @(posedge clk); #1;
        chk("rst_start_idle", ob_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tt_sweep_checker
`default_nettype wire
